// File: rtl/de0_debug_scan_pkg.sv
// Shared types and default sizing for the virtual-JTAG debug scan master.
// No logic, no latency, no backpressure.
package de0_debug_scan_pkg;

  localparam int DR_WIDTH_DEF = 38;
  localparam int IR_WIDTH_DEF = 2;

  // Counter must be able to hold DR_WIDTH itself, hence the +1.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int CNT_W_DEF = $clog2(DR_WIDTH_DEF + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UIR,
    ST_CDR,
    ST_SDR,
    ST_UDR,
    ST_RSP
  } state_t;

endpackage

// File: rtl/de0_debug_scan_sr.sv
// Load/shift data register, LSB leaves first, new bits enter at the MSB.
// One cycle per load or shift; no backpressure, load wins over shift.
module de0_debug_scan_sr
  import de0_debug_scan_pkg::*;
#(
  parameter int WIDTH = DR_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_dat,
  input  logic             shift_en,
  input  logic             tdo,
  output logic             sr0,
  output logic [WIDTH-1:0] sr_val
);

  logic [WIDTH-1:0] sr;

  always_ff @(posedge clk) begin
    if (reset) begin
      sr <= '0;
    end else if (load) begin
      sr <= load_dat;
    end else if (shift_en) begin
      sr <= {tdo, sr[WIDTH-1:1]};
    end
  end

  assign sr0    = sr[0];
  assign sr_val = sr;

endmodule

// File: rtl/de0_debug_scan_master.sv
// Command-driven virtual-JTAG scan master: one IR update, optional DR scan, one response.
// Response DR_WIDTH+4 cycles after handshake (2 for IR-only); holds in RSP until rsp_ready.
module de0_debug_scan_master
  import de0_debug_scan_pkg::*;
#(
  parameter int DR_WIDTH = DR_WIDTH_DEF,
  parameter int IR_WIDTH = IR_WIDTH_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_dr,
  input  logic                cmd_ir_only,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DR_WIDTH-1:0] rsp_dr,
  output logic [IR_WIDTH-1:0] rsp_ir_capture,
  output logic [IR_WIDTH-1:0] ir_in,
  output logic                vs_uir,
  output logic                vs_cdr,
  output logic                vs_sdr,
  output logic                vs_udr,
  output logic                jtag_state_rti,
  output logic                tdi,
  input  logic                tdo,
  input  logic [IR_WIDTH-1:0] ir_out,
  output logic                busy
);

  localparam int CNT_W = cnt_width(DR_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DR_WIDTH - 1);

  state_t              state, state_nxt;
  logic [DR_WIDTH-1:0] dr_q;
  logic                ir_only_q;
  logic [CNT_W-1:0]    bit_cnt;
  logic [IR_WIDTH-1:0] ir_q;
  logic [IR_WIDTH-1:0] cap_q;
  logic                sr_load;
  logic                sr_shift;
  logic                sr0;
  logic [DR_WIDTH-1:0] sr_val;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      dr_q      <= '0;
      ir_only_q <= 1'b0;
      bit_cnt   <= '0;
      ir_q      <= '0;
      cap_q     <= '0;
    end else begin
      state <= state_nxt;
      // ir_q doubles as ir_in, so it keeps driving the slave until the next command.
      if (state == ST_IDLE && cmd_valid) begin
        ir_q      <= cmd_ir;
        dr_q      <= cmd_dr;
        ir_only_q <= cmd_ir_only;
      end
      if (state == ST_UIR) begin
        cap_q <= ir_out;
      end
      if (state == ST_CDR) begin
        bit_cnt <= '0;
      end else if (state == ST_SDR) begin
        bit_cnt <= bit_cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    cmd_ready      = 1'b0;
    rsp_valid      = 1'b0;
    vs_uir         = 1'b0;
    vs_cdr         = 1'b0;
    vs_sdr         = 1'b0;
    vs_udr         = 1'b0;
    jtag_state_rti = 1'b0;
    tdi            = 1'b0;
    sr_load        = 1'b0;
    sr_shift       = 1'b0;
    busy           = 1'b1;
    case (state)
      ST_IDLE: begin
        cmd_ready      = 1'b1;
        jtag_state_rti = 1'b1;
        busy           = 1'b0;
        if (cmd_valid) state_nxt = ST_UIR;
      end
      ST_UIR: begin
        vs_uir    = 1'b1;
        state_nxt = ir_only_q ? ST_RSP : ST_CDR;
      end
      ST_CDR: begin
        vs_cdr    = 1'b1;
        sr_load   = 1'b1;
        state_nxt = ST_SDR;
      end
      ST_SDR: begin
        vs_sdr   = 1'b1;
        tdi      = sr0;
        sr_shift = 1'b1;
        if (bit_cnt == CNT_LAST) state_nxt = ST_UDR;
      end
      ST_UDR: begin
        vs_udr    = 1'b1;
        state_nxt = ST_RSP;
      end
      ST_RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  de0_debug_scan_sr #(
    .WIDTH(DR_WIDTH)
  ) u_sr (
    .clk     (clk),
    .reset   (reset),
    .load    (sr_load),
    .load_dat(dr_q),
    .shift_en(sr_shift),
    .tdo     (tdo),
    .sr0     (sr0),
    .sr_val  (sr_val)
  );

  // An IR-only command never loads sr, so mask any value left from an earlier scan.
  assign rsp_dr         = ir_only_q ? '0 : sr_val;
  assign rsp_ir_capture = cap_q;
  assign ir_in          = ir_q;

endmodule

// File: tb/tb_de0_debug_scan_master.sv
// Scoreboard bench for de0_debug_scan_master: expectations queued at drive time,
// popped when rsp_valid rises; a negedge monitor also models the DR shift.
module tb_de0_debug_scan_master;

  localparam int DW = 38;
  localparam int IW = 2;

  typedef struct {
    logic [IW-1:0] ir;
    logic [DW-1:0] dr;
    logic          ir_only;
    logic [DW-1:0] rdr;
    logic [IW-1:0] cap;
    int            lat;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [IW-1:0] cmd_ir = '0;
  logic [DW-1:0] cmd_dr = '0;
  logic          cmd_ir_only = 1'b0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_dr;
  logic [IW-1:0] rsp_ir_capture;
  logic [IW-1:0] ir_in;
  logic          vs_uir, vs_cdr, vs_sdr, vs_udr;
  logic          jtag_state_rti;
  logic          tdi;
  logic          tdo;
  logic [IW-1:0] ir_out;
  logic          busy;

  logic          loop = 1'b0;
  logic          tdo_fix = 1'b0;
  logic [IW-1:0] ir_out_val = '0;

  assign tdo    = loop ? tdi : tdo_fix;
  assign ir_out = ir_out_val;

  de0_debug_scan_master #(
    .DR_WIDTH(DW),
    .IR_WIDTH(IW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_ir        (cmd_ir),
    .cmd_dr        (cmd_dr),
    .cmd_ir_only   (cmd_ir_only),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_dr        (rsp_dr),
    .rsp_ir_capture(rsp_ir_capture),
    .ir_in         (ir_in),
    .vs_uir        (vs_uir),
    .vs_cdr        (vs_cdr),
    .vs_sdr        (vs_sdr),
    .vs_udr        (vs_udr),
    .jtag_state_rti(jtag_state_rti),
    .tdi           (tdi),
    .tdo           (tdo),
    .ir_out        (ir_out),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int hs_cyc = 0;
  int sdr_n = 0;
  bit started = 1'b0;
  bit rsp_prev = 1'b0;
  logic [DW-1:0] m_sr = '0;
  logic [DW-1:0] held = '0;
  exp_t exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Protocol monitor and DR shift model.
  always @(negedge clk) begin
    if (reset || !started) begin
      rsp_prev = 1'b0;
    end else begin
      chk("strobe_onehot", 64'($countones({vs_uir, vs_cdr, vs_sdr, vs_udr}) <= 1), 64'd1);
      if (!vs_sdr && tdi) chk("tdi_outside_sdr", tdi, 0);
      if (cmd_valid && cmd_ready) hs_cyc = cyc;
      if (vs_uir) begin
        if (exp_q.size() == 0) chk("uir_unexpected", 0, 1);
        else begin
          chk("uir_ir_in", ir_in, exp_q[0].ir);
          chk("uir_latency", cyc - hs_cyc, 1);
        end
      end
      if (vs_cdr) begin
        if (exp_q.size() == 0) chk("cdr_unexpected", 0, 1);
        else begin
          chk("cdr_on_ir_only", exp_q[0].ir_only, 0);
          m_sr = exp_q[0].dr;
        end
        sdr_n = 0;
      end
      if (vs_sdr) begin
        chk("sdr_tdi", tdi, m_sr[0]);
        m_sr = {tdo, m_sr[DW-1:1]};
        sdr_n++;
      end
      if (vs_udr) begin
        if (exp_q.size() == 0) chk("udr_unexpected", 0, 1);
        else chk("sdr_length", sdr_n, DW);
      end
      if (rsp_valid && !rsp_prev) begin
        if (exp_q.size() == 0) chk("rsp_unexpected", 0, 1);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("rsp_dr", rsp_dr, e.rdr);
          chk("rsp_ir_capture", rsp_ir_capture, e.cap);
          chk("rsp_latency", cyc - hs_cyc, e.lat);
          held = rsp_dr;
        end
      end else if (rsp_valid) begin
        chk("rsp_dr_stable", rsp_dr, held);
      end
      rsp_prev = rsp_valid;
    end
  end

  function automatic exp_t mk(input logic [IW-1:0] ir, input logic [DW-1:0] dr, input logic only,
                              input logic [DW-1:0] rdr, input logic [IW-1:0] cap);
    exp_t e;
    e.ir = ir; e.dr = dr; e.ir_only = only; e.rdr = rdr; e.cap = cap;
    e.lat = only ? 2 : DW + 4;
    return e;
  endfunction

  task automatic present(input logic [IW-1:0] ir, input logic [DW-1:0] dr, input logic only);
    cmd_ir = ir; cmd_dr = dr; cmd_ir_only = only; cmd_valid = 1'b1;
  endtask

  task automatic wait_hs();
    int n = 0;
    do begin @(negedge clk); n++; end while (!cmd_ready && n < 100);
    if (!cmd_ready) chk("cmd_hs_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [IW-1:0] ir, input logic [DW-1:0] dr, input logic only,
                      input logic [DW-1:0] rdr, input logic [IW-1:0] cap);
    exp_q.push_back(mk(ir, dr, only, rdr, cap));
    present(ir, dr, only);
    wait_hs();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp_done();
    int n = 0;
    do begin @(negedge clk); n++; end while (!(rsp_valid && rsp_ready) && n < 200);
    if (!(rsp_valid && rsp_ready)) chk("rsp_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [DW-1:0] rdat;
    logic [IW-1:0] rir;
    int n, r;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_rti", jtag_state_rti, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_tdi", tdi, 0);
    chk("rst_strobes", {vs_uir, vs_cdr, vs_sdr, vs_udr}, 0);
    chk("rst_ir_in", ir_in, 0);
    chk("rst_rsp_dr", rsp_dr, 0);
    chk("rst_rsp_ir_capture", rsp_ir_capture, 0);
    started = 1'b1;
    @(posedge clk); #1;

    // Loopback with alternating pattern.
    loop = 1'b1; ir_out_val = 2'b10;
    send(2'b01, 38'h15_5555_5555, 1'b0, 38'h15_5555_5555, 2'b10);
    wait_rsp_done();

    // tdo stuck high, zero data in.
    loop = 1'b0; tdo_fix = 1'b1; ir_out_val = 2'b00;
    send(2'b11, 38'h0, 1'b0, 38'h3F_FFFF_FFFF, 2'b00);
    wait_rsp_done();

    // IR-only; sr still holds all-ones from the previous scan.
    ir_out_val = 2'b11;
    send(2'b10, 38'h2A_AAAA_AAAA, 1'b1, 38'h0, 2'b11);
    wait_rsp_done();
    chk("ir_in_hold", ir_in, 2'b10);

    // Random loopback commands.
    loop = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rdat = {6'($urandom), 32'($urandom)};
      rir = 2'($urandom);
      ir_out_val = 2'($urandom);
      send(rir, rdat, 1'b0, rdat, ir_out_val);
      wait_rsp_done();
    end

    // Response backpressure with a competing command.
    rsp_ready = 1'b0; ir_out_val = 2'b01;
    send(2'b00, 38'h01_2345_6789, 1'b0, 38'h01_2345_6789, 2'b01);
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp_valid && n < 100);
    if (!rsp_valid) chk("bp_rsp_timeout", 0, 1);
    @(posedge clk); #1;
    present(2'b11, 38'h3F_0000_FFFF, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_cmd_ready", cmd_ready, 0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1; cmd_valid = 1'b0;
    @(negedge clk);
    chk("bp_still_rsp", rsp_valid, 1);
    @(negedge clk);
    chk("bp_released_rsp", rsp_valid, 0);
    chk("bp_released_ready", cmd_ready, 1);
    @(negedge clk);
    chk("bp_no_late_cmd", busy, 0);
    @(posedge clk); #1;

    // Reset in the middle of SDR.
    loop = 1'b1;
    send(2'b01, 38'h0F_F0F0_0F0F, 1'b0, 38'h0F_F0F0_0F0F, ir_out_val);
    while (cyc != hs_cyc + 20) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(negedge clk);
    chk("mid_sdr_active", vs_sdr, 1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_cmd_ready", cmd_ready, 1);
    chk("rst_mid_vs_sdr", vs_sdr, 0);
    chk("rst_mid_rsp_dr", rsp_dr, 0);
    exp_q.delete();
    repeat (50) @(negedge clk);
    chk("rst_mid_idle", busy, 0);
    @(posedge clk); #1;

    // Back-to-back with cmd_valid held high.
    exp_q.push_back(mk(2'b10, 38'h12_3456_789A, 1'b0, 38'h12_3456_789A, ir_out_val));
    exp_q.push_back(mk(2'b01, 38'h2B_CDEF_0123, 1'b0, 38'h2B_CDEF_0123, ir_out_val));
    present(2'b10, 38'h12_3456_789A, 1'b0);
    wait_hs();
    present(2'b01, 38'h2B_CDEF_0123, 1'b0);
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp_valid && n < 100);
    if (!rsp_valid) chk("b2b_rsp_timeout", 0, 1);
    r = cyc;
    n = 0;
    do begin @(negedge clk); n++; end while (!vs_uir && n < 100);
    chk("b2b_uir_gap", cyc - r, 2);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    wait_rsp_done();

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/de0_debug_scan_master.md
DE0_DEBUG_SCAN_MASTER -- requirements
Module: de0_debug_scan_master

Interface
REQ-001 Parameter DR_WIDTH, default 38, data-register scan length in bits.
REQ-002 Parameter IR_WIDTH, default 2, instruction-register width in bits.
REQ-003 Port clk  in  1  sole clock; all logic SHALL be clocked on its rising edge.
REQ-004 Port reset  in  1  synchronous, active-high reset.
REQ-005 Port cmd_valid / cmd_ready  in / out  1 / 1  command handshake; transfer when both are high on a clk edge.
REQ-006 Port cmd_ir  in  IR_WIDTH  instruction to load into the target.
REQ-007 Port cmd_dr  in  DR_WIDTH  data to shift into the target.
REQ-008 Port cmd_ir_only  in  1  when high, the command updates IR only; no DR scan.
REQ-009 Port rsp_valid / rsp_ready  out / in  1 / 1  response handshake.
REQ-010 Port rsp_dr  out  DR_WIDTH  bits shifted out of the target.
REQ-011 Port rsp_ir_capture  out  IR_WIDTH  ir_out sampled during the UIR cycle.
REQ-012 Ports ir_in (out, IR_WIDTH), vs_uir, vs_cdr, vs_sdr, vs_udr, jtag_state_rti, tdi (out, 1 each): virtual-JTAG drive toward the debug slave.
REQ-013 Ports tdo (in, 1) and ir_out (in, IR_WIDTH): virtual-JTAG return from the debug slave.
REQ-014 Port busy  out  1  high in every state except IDLE.

Function
REQ-015 FSM states SHALL be IDLE, UIR, CDR, SDR, UDR and RSP.
REQ-016 IDLE: cmd_ready=1, jtag_state_rti=1, tdi=0, all vs_* strobes 0.
REQ-017 IDLE->UIR on cmd handshake; cmd_ir, cmd_dr and cmd_ir_only SHALL be latched.
REQ-018 UIR lasts 1 cycle: vs_uir=1, ir_in=latched cmd_ir; ir_out SHALL be captured into rsp_ir_capture at the end of the cycle.
REQ-019 ir_in SHALL hold its value after UIR until the next UIR.
REQ-020 UIR->RSP if cmd_ir_only; otherwise UIR->CDR.
REQ-021 CDR lasts 1 cycle with vs_cdr=1; the shift register SHALL be loaded with cmd_dr and the bit counter cleared.
REQ-022 SDR lasts exactly DR_WIDTH cycles with vs_sdr=1.
REQ-023 In each SDR cycle, tdi SHALL equal sr[0]; at the edge, sr SHALL take {tdo, sr[DR_WIDTH-1:1]}. Data is LSB first.
REQ-024 The bit counter SHALL be ceil(log2(DR_WIDTH+1)) bits wide; SDR->UDR when it reaches DR_WIDTH-1.
REQ-025 UDR lasts 1 cycle with vs_udr=1; sr is frozen. UDR->RSP.
REQ-026 RSP: rsp_valid=1; rsp_dr=sr, stable while rsp_valid is high; RSP->IDLE on rsp_ready.
REQ-027 If cmd_ir_only, rsp_dr SHALL read 0.
REQ-028 Latency with DR_WIDTH=38: handshake at cycle 0; UIR at 1; CDR at 2; SDR at 3..40; UDR at 41; rsp_valid from 42. IR-only: rsp_valid from 2.
REQ-029 At most one vs_* strobe SHALL be high in any cycle.
REQ-030 cmd_valid outside IDLE SHALL be ignored. Back-to-back: the earliest next handshake is 1 cycle after the response handshake.
REQ-031 Outside SDR, tdo SHALL be ignored.

Reset
REQ-032 On reset the FSM SHALL go to IDLE next cycle from any state, including mid-SDR, with no vs_udr emitted.
REQ-033 Reset values: sr=0, counter=0, ir_in=0, rsp_dr=0, rsp_ir_capture=0, rsp_valid=0, vs_*=0, tdi=0, busy=0, cmd_ready=1, jtag_state_rti=1.

Structure
REQ-034 Package de0_debug_scan_pkg SHALL hold the FSM state enum, DR_WIDTH/IR_WIDTH defaults and the counter-width constant.
REQ-035 Sub-module de0_debug_scan_sr SHALL implement the load/shift register: load, shift_en, tdo in; sr[0] and parallel value out.

Verification
REQ-036 Loopback (tdo=tdi), cmd_ir=2'b01, cmd_dr=38'h15_5555_5555 -> tdi sequence is 1,0,1,0,... in cycles 3..40; rsp_dr=38'h15_5555_5555; rsp_valid at cycle 42.
REQ-037 tdo tied 1, cmd_dr=38'h0 -> tdi=0 for all 38 SDR cycles; rsp_dr=38'h3F_FFFF_FFFF.
REQ-038 cmd_ir_only=1, cmd_ir=2'b10, ir_out=2'b11 -> single vs_uir pulse with ir_in=2'b10; no vs_cdr/sdr/udr; rsp_valid at cycle 2; rsp_ir_capture=2'b11; rsp_dr=0.
REQ-039 rsp_ready held low for 10 cycles after rsp_valid -> rsp_valid and rsp_dr stable, cmd_ready=0, cmd_valid ignored; then RSP->IDLE the cycle after rsp_ready=1.
REQ-040 reset pulsed at cycle 20 (mid-SDR) -> at cycle 21 cmd_ready=1, vs_sdr=0, rsp_dr=0; no vs_udr or rsp_valid ever seen for that command.
REQ-041 Two commands with cmd_valid held high and rsp_ready=1 -> second UIR exactly 2 cycles after the first rsp_valid; the one-hot strobe check passes throughout.
